hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous, active-low reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-low reset.
REQ-002 ID_rs  input  5  source register of the instruction in ID.
REQ-003 ID_rt  input  5  second source register of the instruction in ID.
REQ-004 ID_UsesRt  input  1  ID instruction reads rt.
REQ-005 ID_Jump  input  1  jump (j/jal/jr/jalr) resolved in ID.
REQ-006 EX_MemRd  input  1  the EX-stage instruction is a load.
REQ-007 EX_WrReg  input  5  destination register of the EX-stage instruction.
REQ-008 EX_BrTaken  input  1  branch in EX resolved as taken.
REQ-009 irq  input  1  level interrupt request.
REQ-010 PC_stall  output  1  hold PC.
REQ-011 IFID_stall  output  1  hold IF/ID register.
REQ-012 IFID_flush  output  1  load NOP into IF/ID.
REQ-013 IDEX_stall  output  1  drives the stall input of the ID/EX register; zeroes MemWr/MemRd/RegWr there (bubble).
REQ-014 IRQ_take  output  1  one-cycle pulse; PC selects the interrupt vector.
REQ-015 state  output  2  current FSM state, for debug.

Function
REQ-016 The FSM SHALL have the states RUN=0, LU_HOLD=1, BR_FLUSH=2 and IRQ_DRAIN=3.
REQ-017 Load-use hazard: EX_MemRd=1, EX_WrReg!=0, and (EX_WrReg==ID_rs, or ID_UsesRt=1 and EX_WrReg==ID_rt).
REQ-018 Priority of simultaneous events: EX_BrTaken > load-use > ID_Jump > irq.
REQ-019 RUN with EX_BrTaken: IFID_flush=1 and IDEX_stall=1 in the same cycle (combinational); next state BR_FLUSH.
REQ-020 BR_FLUSH: IFID_flush=1 for exactly one cycle; all hazard and irq inputs ignored; next state RUN.
REQ-021 RUN with load-use: PC_stall=IFID_stall=IDEX_stall=1 (combinational); next state LU_HOLD.
REQ-022 LU_HOLD: no stall outputs asserted; load-use is not re-evaluated; irq is not taken; next state RUN. Total penalty is exactly 1 bubble.
REQ-023 RUN with ID_Jump and no higher-priority event: IFID_flush=1 for that cycle only; state stays RUN.
REQ-024 RUN with irq=1, no other event, and the irq mask clear: IRQ_take=1, IFID_flush=1 and IDEX_stall=1; set the irq mask; next state IRQ_DRAIN.
REQ-025 IRQ_DRAIN: IFID_flush=1 for 2 consecutive cycles, counted by a 1-bit counter; then return to RUN.
REQ-026 The irq mask SHALL clear only when irq is sampled low, so one request level yields exactly one IRQ_take.
REQ-027 Outputs not named for a state/event SHALL be 0; IRQ_take SHALL never be high for more than 1 cycle.
REQ-028 EX_WrReg=0 SHALL never cause a stall.

Reset
REQ-029 reset=0 at a rising clk edge: state=RUN, irq mask=0, drain counter=0, performance counters=0.
REQ-030 While reset=0: IDEX_stall=1 and all other outputs 0.
REQ-031 Reset asserted in any state (including mid-drain) SHALL abort the sequence with no residual flush on the cycle after release.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: add outputs stall_cnt (32 bits, +1 per cycle with PC_stall=1) and flush_cnt (32 bits, +1 per cycle with IFID_flush=1).
REQ-033 Both counters SHALL wrap modulo 2^32 and be cleared by reset.
REQ-034 Macro HAZARD_PERF_CNT_EN undefined: these ports and registers are absent; all other behaviour is identical.

Structure
REQ-035 The state encodings (RUN/LU_HOLD/BR_FLUSH/IRQ_DRAIN) and the IRQ_DRAIN length constant (2) SHALL live in the shared pipeline package.
REQ-036 Hazard detection (REQ-017, REQ-028) SHALL be a combinational sub-module, loaduse_detect; the FSM stays in hazard_ctrl.

Verification
REQ-037 EX_MemRd=1, EX_WrReg=8, ID_rs=8 -> stall outputs high for 1 cycle, state 0->1->0, then no stall.
REQ-038 EX_MemRd=1, EX_WrReg=0, ID_rs=0 -> no stall; ID_rt=9 with ID_UsesRt=0 and EX_WrReg=9 -> no stall.
REQ-039 EX_BrTaken=1 together with a load-use match -> IFID_flush+IDEX_stall for 1 cycle, then IFID_flush 1 cycle, PC_stall never high.
REQ-040 irq held high for 10 cycles in RUN -> single IRQ_take pulse, IFID_flush high for 3 cycles total; irq low then high again -> second pulse.
REQ-041 reset=0 during IRQ_DRAIN cycle 1 -> next cycle state=0, IDEX_stall=1 only; after release, no flush.
REQ-042 HAZARD_PERF_CNT_EN defined with 3 load-use and 1 branch event -> stall_cnt=3, flush_cnt=2.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline hazard-control definitions: FSM encodings, drain length and control bundle.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W         = 5;
    localparam int unsigned STATE_W       = 2;
    localparam int unsigned PERF_CNT_W    = 32;
    localparam int unsigned IRQ_DRAIN_LEN = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN       = 2'd0,
        ST_LU_HOLD   = 2'd1,
        ST_BR_FLUSH  = 2'd2,
        ST_IRQ_DRAIN = 2'd3
    } hz_state_e;

    // Pipeline control bundle driven toward PC, IF/ID and ID/EX
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic irq_take;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_loaduse_detect.sv
// Combinational load-use detector: EX load whose destination feeds the ID instruction.
module loaduse_detect
    import hazard_ctrl_pkg::*;
(
    input  logic             ex_memrd_i,
    input  logic [REG_W-1:0] ex_wrreg_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    output logic             hazard_o
);

    logic rs_match;
    logic rt_match;

    // Register 0 is hard-wired zero and never creates a dependency
    assign rs_match = (ex_wrreg_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_wrreg_i == id_rt_i);
    assign hazard_o = ex_memrd_i && (ex_wrreg_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / interrupt control FSM; HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   ID_rs,
    input  logic [REG_W-1:0]   ID_rt,
    input  logic               ID_UsesRt,
    input  logic               ID_Jump,
    input  logic               EX_MemRd,
    input  logic [REG_W-1:0]   EX_WrReg,
    input  logic               EX_BrTaken,
    input  logic               irq,
    output logic               PC_stall,
    output logic               IFID_stall,
    output logic               IFID_flush,
    output logic               IDEX_stall,
    output logic               IRQ_take,
    output logic [STATE_W-1:0] state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    hz_state_e state_q, state_d;
    logic      drain_q, drain_d;
    logic      mask_q,  mask_d;
    logic      lu_hazard;
    hz_ctrl_t  ctrl;

    loaduse_detect u_loaduse_detect (
        .ex_memrd_i   (EX_MemRd),
        .ex_wrreg_i   (EX_WrReg),
        .id_rs_i      (ID_rs),
        .id_rt_i      (ID_rt),
        .id_uses_rt_i (ID_UsesRt),
        .hazard_o     (lu_hazard)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            drain_q <= 1'b0;
            mask_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            mask_q  <= mask_d;
        end
    end

    // Next state and same-cycle pipeline controls
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        mask_d  = mask_q;
        ctrl    = '0;

        // Mask re-arms only once the request level has dropped
        if (!irq) begin
            mask_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (EX_BrTaken) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_stall = 1'b1;
                    state_d         = ST_BR_FLUSH;
                end else if (lu_hazard) begin
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_stall = 1'b1;
                    ctrl.idex_stall = 1'b1;
                    state_d         = ST_LU_HOLD;
                end else if (ID_Jump) begin
                    ctrl.ifid_flush = 1'b1;
                end else if (irq && !mask_q) begin
                    ctrl.irq_take   = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_stall = 1'b1;
                    mask_d          = 1'b1;
                    drain_d         = 1'b0;
                    state_d         = ST_IRQ_DRAIN;
                end
            end
            ST_LU_HOLD: begin
                state_d = ST_RUN;
            end
            ST_BR_FLUSH: begin
                ctrl.ifid_flush = 1'b1;
                state_d         = ST_RUN;
            end
            ST_IRQ_DRAIN: begin
                ctrl.ifid_flush = 1'b1;
                if (drain_q == 1'(IRQ_DRAIN_LEN - 1)) begin
                    drain_d = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // While in reset only the ID/EX bubble is held
        if (!reset) begin
            ctrl            = '0;
            ctrl.idex_stall = 1'b1;
        end
    end

    assign PC_stall   = ctrl.pc_stall;
    assign IFID_stall = ctrl.ifid_stall;
    assign IFID_flush = ctrl.ifid_flush;
    assign IDEX_stall = ctrl.idex_stall;
    assign IRQ_take   = ctrl.irq_take;
    assign state      = reset ? STATE_W'(state_q) : STATE_W'(ST_RUN);

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q;
    logic [PERF_CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctrl.pc_stall) begin
                stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
            end
            if (ctrl.ifid_flush) begin
                flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

    assign stall_cnt = reset ? stall_cnt_q : '0;
    assign flush_cnt = reset ? flush_cnt_q : '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt, EX_WrReg;
    logic       ID_UsesRt, ID_Jump, EX_MemRd, EX_BrTaken, irq;
    logic       PC_stall, IFID_stall, IFID_flush, IDEX_stall, IRQ_take;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: remaining forced-flush cycles, pending quiet cycle after a load-use, irq mask
    int          m_flush_left;
    bit          m_quiet, m_in_irq, m_mask;
    bit   [31:0] m_stall_cnt, m_flush_cnt;
    logic [6:0]  obs, expv;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_UsesRt  (ID_UsesRt),
        .ID_Jump    (ID_Jump),
        .EX_MemRd   (EX_MemRd),
        .EX_WrReg   (EX_WrReg),
        .EX_BrTaken (EX_BrTaken),
        .irq        (irq),
        .PC_stall   (PC_stall),
        .IFID_stall (IFID_stall),
        .IFID_flush (IFID_flush),
        .IDEX_stall (IDEX_stall),
        .IRQ_take   (IRQ_take),
        .state      (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    function automatic bit load_use();
        return EX_MemRd && (EX_WrReg != 5'd0) &&
               ((EX_WrReg == ID_rs) || (ID_UsesRt && (EX_WrReg == ID_rt)));
    endfunction

    // Vector layout: {PC_stall, IFID_stall, IFID_flush, IDEX_stall, IRQ_take, state}
    function automatic logic [6:0] model_out();
        logic pcs, ifs, fl, ids, tk;
        logic [1:0] st;
        pcs = 1'b0; ifs = 1'b0; fl = 1'b0; ids = 1'b0; tk = 1'b0; st = 2'd0;
        if (!reset) return 7'b0001000;
        if (m_flush_left > 0) begin
            fl = 1'b1;
            st = m_in_irq ? 2'd3 : 2'd2;
        end else if (m_quiet) begin
            st = 2'd1;
        end else if (EX_BrTaken) begin
            fl = 1'b1; ids = 1'b1;
        end else if (load_use()) begin
            pcs = 1'b1; ifs = 1'b1; ids = 1'b1;
        end else if (ID_Jump) begin
            fl = 1'b1;
        end else if (irq && !m_mask) begin
            tk = 1'b1; fl = 1'b1; ids = 1'b1;
        end
        return {pcs, ifs, fl, ids, tk, st};
    endfunction

    task automatic model_update(input logic [6:0] e);
        if (!reset) begin
            m_flush_left = 0; m_quiet = 1'b0; m_in_irq = 1'b0; m_mask = 1'b0;
            m_stall_cnt = 32'd0; m_flush_cnt = 32'd0;
            return;
        end
        m_stall_cnt = m_stall_cnt + 32'(e[6]);
        m_flush_cnt = m_flush_cnt + 32'(e[4]);
        if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (m_quiet) begin
            m_quiet = 1'b0;
        end else if (EX_BrTaken) begin
            m_flush_left = 1; m_in_irq = 1'b0;
        end else if (load_use()) begin
            m_quiet = 1'b1;
        end else if (e[2]) begin
            m_flush_left = 2; m_in_irq = 1'b1; m_mask = 1'b1;
        end
        if (!irq) m_mask = 1'b0;
    endtask

    // Drive one cycle, compare against the model before the edge, advance the model on the edge
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic jp, input logic mr,
                        input logic [4:0] wr, input logic br, input logic iq);
        reset = rst; ID_rs = rs; ID_rt = rt; ID_UsesRt = ur; ID_Jump = jp;
        EX_MemRd = mr; EX_WrReg = wr; EX_BrTaken = br; irq = iq;
        #1;
        obs  = {PC_stall, IFID_stall, IFID_flush, IDEX_stall, IRQ_take, state};
        expv = model_out();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, obs, expv);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== (reset ? m_stall_cnt : 32'd0) ||
            flush_cnt !== (reset ? m_flush_cnt : 32'd0)) begin
            errors++;
            $display("FAIL perf_cmp t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                     stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
        end
`endif
        @(posedge clk);
        model_update(expv);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic lit_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    initial begin
        int takes;
        int flushes;
        logic irq_lvl;
        logic rst_r;

        m_flush_left = 0; m_quiet = 1'b0; m_in_irq = 1'b0; m_mask = 1'b0;
        m_stall_cnt = 32'd0; m_flush_cnt = 32'd0;

        // Reset
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            lit("reset_out", obs, 7'b0001000);
        end
        idle();
        lit("after_reset", obs, 7'b0000000);

        // Load-use on rs: one bubble, 0 -> 1 -> 0
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        lit("lu_stall", obs, 7'b1101000);
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        lit("lu_hold", obs, 7'b0000001);
        idle();
        lit("lu_done", obs, 7'b0000000);

        // No stall for r0 or for an unused rt
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        lit("lu_r0", obs, 7'b0000000);
        step(1'b1, 5'd1, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        lit("lu_rt_unused", obs, 7'b0000000);
        step(1'b1, 5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        lit("lu_rt_used", obs, 7'b1101000);
        idle();

        // Branch beats load-use
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        lit("br_c0", obs, 7'b0011000);
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
        lit("br_flush", obs, 7'b0010010);
        idle();
        lit("br_done", obs, 7'b0000000);

        // Jump flushes one cycle, stays in RUN
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        lit("jump", obs, 7'b0010000);
        idle();

        // Held irq: one take, three flush cycles
        takes = 0; flushes = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            if (i == 0) lit("irq_take", obs, 7'b0011100);
            if (i == 1) lit("irq_drain", obs, 7'b0010011);
            takes   += int'(obs[2]);
            flushes += int'(obs[4]);
        end
        lit_int("irq_take_cnt", takes, 1);
        lit_int("irq_flush_cnt", flushes, 3);
        idle();
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        lit("irq_retake", obs, 7'b0011100);
        idle();
        idle();
        idle();

        // Reset mid-drain aborts with no residual flush
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        lit("irq_take2", obs, 7'b0011100);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        lit("rst_drain", obs, 7'b0001000);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        lit("rst_drain2", obs, 7'b0001000);
        idle();
        lit("rst_release", obs, 7'b0000000);

        // Three load-use events and one branch
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
            idle();
        end
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle();
        idle();
`ifdef HAZARD_PERF_CNT_EN
        lit_int("stall_cnt", int'(stall_cnt), 3);
        lit_int("flush_cnt", int'(flush_cnt), 2);
`endif

        // Randomized traffic with held irq levels and occasional reset
        irq_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(63) != 0);
            if ($urandom_range(5) == 0) irq_lvl = ~irq_lvl;
            step(rst_r, 5'($urandom_range(3)), 5'($urandom_range(3)),
                 1'($urandom_range(1)), ($urandom_range(7) == 0),
                 ($urandom_range(2) == 0), 5'($urandom_range(3)),
                 ($urandom_range(7) == 0), irq_lvl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
